// File: rtl/full_subtractor_8bit.sv
// Unsigned WIDTH-bit ripple-borrow subtractor: {bout, d} <= a - b - bin, one cycle latency.
// Borrow chain is combinational from the pins; only the result is registered.

module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module full_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff;

    assign borrow[0] = bin;

    // One cell per bit; the critical path is bin/a[0]/b[0] rippling up to borrow[WIDTH].
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (borrow[i]),
            .d    (diff[i]),
            .bout (borrow[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
        end else begin
            d    <= diff;
            bout <= borrow[WIDTH];
        end
    end
endmodule

// File: tb/tb_full_subtractor_8bit.sv
// Directed and random checks for full_subtractor_8bit with hand-computed expectations.

module tb_full_subtractor_8bit;
    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bout;

    int checks   = 0;
    int failures = 0;

    full_subtractor_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {bout,d}=%h expected %h", tag, got, exp);
        end
    endtask

    // Drive a vector mid-cycle, then check just after the capturing edge.
    task automatic apply(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vbin, input logic [8:0] exp);
        @(negedge clk);
        a = va; b = vb; bin = vbin;
        @(posedge clk);
        #1;
        chk(tag, {bout, d}, exp);
    endtask

    logic [7:0] ra, rb;
    logic [8:0] rexp;

    initial begin
        rst_n = 1'b0;
        a = 8'd200; b = 8'd100; bin = 1'b1;

        // Outputs held at zero through several edges while in reset.
        #2;
        chk("rst_t0", {bout, d}, 9'h000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", {bout, d}, 9'h000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("basic_200_100_1", {bout, d}, 9'd99);

        // Same inputs again: output must not change.
        @(posedge clk);
        #1;
        chk("hold", {bout, d}, 9'd99);

        apply("basic_100_99_1", 8'd100, 8'd99,  1'b1, 9'h000);
        apply("wrap_5_10_0",    8'd5,   8'd10,  1'b0, 9'h1FB);
        apply("wrap_0_0_1",     8'd0,   8'd0,   1'b1, 9'h1FF);
        apply("ext_ff_ff_1",    8'd255, 8'd255, 1'b1, 9'h1FF);
        apply("eq_77_77_0",     8'd77,  8'd77,  1'b0, 9'h000);
        apply("ext_ff_00_0",    8'd255, 8'd0,   1'b0, 9'h0FF);
        apply("ext_00_ff_1",    8'd0,   8'd255, 1'b1, 9'h100);

        // Back-to-back vectors, one per cycle: each result lands exactly one edge later.
        apply("tput0", 8'd10,  8'd3,   1'b0, 9'd7);
        apply("tput1", 8'd10,  8'd3,   1'b1, 9'd6);
        apply("tput2", 8'd128, 8'd129, 1'b0, 9'h1FF);
        apply("tput3", 8'd50,  8'd20,  1'b1, 9'd29);

        // Asynchronous reset between edges clears outputs with no clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bout, d}, 9'h000);
        a = 8'd9; b = 8'd4; bin = 1'b0;
        @(posedge clk);
        #1;
        chk("async_rst_hold", {bout, d}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_capture", {bout, d}, 9'd5);

        for (int i = 0; i < 10; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rexp = 9'(({1'b0, ra} - {1'b0, rb} - ((i < 5) ? 9'd1 : 9'd0)) & 9'h1FF);
            apply($sformatf("rand%0d", i), ra, rb, (i < 5), rexp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/full_subtractor_8bit.md
Name: full_subtractor_8bit

Overview:
- Unsigned 8-bit subtractor with borrow-in and borrow-out. Computes a − b − bin as a ripple-borrow chain of 1-bit full-subtractor cells.
- The difference and the borrow-out are registered on the clock, giving one cycle of latency.
- Used as a standalone arithmetic block or as a slice of a wider subtractor, chained via bin/bout.

Parameters:
- WIDTH, 8, operand and difference width in bits. The block must be correct for any WIDTH ≥ 1; 8 is the delivered configuration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in; weight 1 at bit 0.
- d  output  WIDTH  registered difference, (a − b − bin) mod 2^WIDTH.
- bout  output  1  registered borrow-out; 1 iff a < b + bin.

Behaviour:
- Reset:
  - rst_n = 0 forces d = 0 and bout = 0 immediately, independent of clk.
  - Outputs hold 0 while rst_n is low.
  - The first capture after release happens on the first rising clk edge with rst_n = 1.
- Arithmetic:
  - {bout, d} = ({1'b0, a} − {1'b0, b} − bin) mod 2^(WIDTH+1), treated as unsigned.
  - When a < b + bin, the result wraps: d = 2^WIDTH + a − b − bin and bout = 1.
  - No signed interpretation and no overflow flag.
- Cell structure, for i = 0..WIDTH−1, with borrow[0] = bin and bout_next = borrow[WIDTH]:
  - diff_i = a[i] ^ b[i] ^ borrow[i]
  - borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i])
- The chain is purely combinational between the input pins and the output registers. Inputs are not registered.
- Latency:
  - Inputs sampled at rising edge N appear on d/bout after edge N and are stable until edge N+1.
  - Full throughput: a new operand set is accepted every cycle.
- Hold: if inputs do not change, outputs keep the same value on every edge.
- Boundaries:
  - a = b, bin = 0 → d = 0, bout = 0.
  - a = b, bin = 1 → d = all ones, bout = 1.
  - a = 0, b = 0, bin = 1 → d = all ones, bout = 1.
  - a = all ones, b = 0, bin = 0 → d = all ones, bout = 0.
  - a = 0, b = all ones, bin = 1 → d = 0, bout = 1 (maximum borrow).
- Reset mid-operation: asserting rst_n clears d/bout asynchronously, and the in-flight result is discarded. After release, the next edge captures the current inputs.
- Reset release coinciding with a clk edge: no capture on that edge. The first capture is on the following edge.
- Timing: one cell delay per bit. The critical path is bin/a[0]/b[0] to bout and must close at the system clock period (10 ns nominal).

Test Plan:
- Reset: hold rst_n = 0 with inputs a = 200, b = 100, bin = 1 and clk toggling → d = 0, bout = 0 throughout. Assert rst_n asynchronously between edges after valid data → d and bout drop to 0 without a clock edge.
- Basic: a = 200, b = 100, bin = 1 → one edge later d = 99, bout = 0. Then a = 100, b = 99, bin = 1 → d = 0, bout = 0.
- Wrap-around: a = 5, b = 10, bin = 0 → d = 251, bout = 1. Then a = 0, b = 0, bin = 1 → d = 255, bout = 1.
- Extremes: a = 255, b = 255, bin = 1 → d = 255, bout = 1. a = 255, b = 0, bin = 0 → d = 255, bout = 0. a = 0, b = 255, bin = 1 → d = 0, bout = 1.
- Latency/throughput: apply a new vector every clock for 4 cycles → each result appears exactly one edge after its inputs were sampled, with no skipped or duplicated results.
- Random: 5 random vectors with bin = 1, then 5 with bin = 0, a and b uniform over 0..255, one vector per 10 ns cycle → {bout, d} matches ({1'b0,a} − {1'b0,b} − bin) mod 512 from a scoreboard model, one cycle delayed.
